// File: rtl/video_pkg.sv
// video_pkg
// Shared Wishbone constants and the word format carried from the stream
// slave port to the SDRAM master port of stream_to_sdram_bridge.
//   CTI_CLASSIC / CTI_END : Wishbone cycle type identifiers
//   BTE_LINEAR            : Wishbone burst type used on the SDRAM bus
//   stream_word_t         : one buffered write (address, byte selects, data)
package video_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } stream_word_t;

  localparam int STREAM_WORD_W = $bits(stream_word_t);

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with show-ahead output: dout presents the oldest entry
// combinationally whenever empty is low.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push, din   : write request and data (ignored when full unless popping)
//   pop, dout   : read request (ignored when empty) and head-of-queue data
//   full, empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is legal when the head leaves on the same edge;
  // the freed slot is the one being written.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/stream_to_sdram_bridge.sv
// stream_to_sdram_bridge
// Wishbone slave for the video stream bus. Write words are buffered in a
// FIFO and replayed, in order, as classic single Wishbone writes on the SDRAM
// bus where this block is master. Reads on the stream side are refused with
// s_err. SDRAM errors drop the word and are counted in drop_cnt; retries
// reissue the same word after one idle cycle.
//   sys_clk, sys_rst_n       : clock, asynchronous active-low reset
//   s_cyc/s_stb/s_we/s_adr/s_dat_ms/s_sel : stream bus request (slave side)
//   s_ack/s_err/s_rty/s_dat_sm             : stream bus response
//   m_cyc/m_stb/m_we/m_adr/m_dat_ms/m_sel/m_cti/m_bte : SDRAM bus request
//   m_ack/m_err/m_rty/m_dat_sm             : SDRAM bus response
//   drop_cnt                 : saturating count of words dropped on m_err
module stream_to_sdram_bridge
  import video_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADR   = 32'h0000_0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        s_cyc,
  input  logic        s_stb,
  input  logic        s_we,
  input  logic [31:0] s_adr,
  input  logic [31:0] s_dat_ms,
  input  logic [3:0]  s_sel,
  output logic        s_ack,
  output logic        s_err,
  output logic        s_rty,
  output logic [31:0] s_dat_sm,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [31:0] m_adr,
  output logic [31:0] m_dat_ms,
  output logic [3:0]  m_sel,
  output logic [2:0]  m_cti,
  output logic [1:0]  m_bte,
  input  logic        m_ack,
  input  logic        m_err,
  input  logic        m_rty,
  input  logic [31:0] m_dat_sm,
  output logic [15:0] drop_cnt
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t       state_reg;
  // Set after m_rty: the word in the m_* registers must be sent again.
  logic         retry_reg;

  stream_word_t fifo_din;
  stream_word_t fifo_dout;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_push;
  logic         fifo_pop;

  // SDRAM read data is never needed; this block only writes.
  logic         unused_dat;
  assign unused_dat = ^m_dat_sm;

  assign s_rty    = 1'b0;
  assign s_dat_sm = 32'h0;
  assign m_we     = m_cyc;
  assign m_cti    = CTI_CLASSIC;
  assign m_bte    = BTE_LINEAR;

  // ~s_ack keeps a held strobe from being accepted twice: the master sees the
  // ack on the same edge and only then moves to its next request.
  assign fifo_push = s_cyc & s_stb & s_we & ~s_ack & ~fifo_full;
  assign fifo_din  = '{adr: s_adr, sel: s_sel, dat: s_dat_ms};
  assign fifo_pop  = (state_reg == IDLE) & ~retry_reg & ~fifo_empty;

  sync_fifo #(
    .WIDTH (STREAM_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
      retry_reg <= 1'b0;
      s_ack     <= 1'b0;
      s_err     <= 1'b0;
      m_cyc     <= 1'b0;
      m_stb     <= 1'b0;
      m_adr     <= 32'h0;
      m_dat_ms  <= 32'h0;
      m_sel     <= 4'h0;
      drop_cnt  <= 16'h0;
    end else begin
      s_ack <= fifo_push;
      // Reads are refused; gating on ~s_err makes a held read strobe see one
      // error pulse per request rather than a level.
      s_err <= s_cyc & s_stb & ~s_we & ~s_err;

      case (state_reg)
        IDLE: begin
          if (retry_reg) begin
            // Address/data/select registers still hold the retried word.
            m_cyc     <= 1'b1;
            m_stb     <= 1'b1;
            retry_reg <= 1'b0;
            state_reg <= WRITE;
          end else if (!fifo_empty) begin
            m_cyc     <= 1'b1;
            m_stb     <= 1'b1;
            m_adr     <= BASE_ADR + fifo_dout.adr;
            m_dat_ms  <= fifo_dout.dat;
            m_sel     <= fifo_dout.sel;
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          if (m_ack) begin
            m_cyc     <= 1'b0;
            m_stb     <= 1'b0;
            state_reg <= IDLE;
          end else if (m_err) begin
            m_cyc     <= 1'b0;
            m_stb     <= 1'b0;
            state_reg <= IDLE;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'h1;
          end else if (m_rty) begin
            m_cyc     <= 1'b0;
            m_stb     <= 1'b0;
            retry_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_to_sdram_bridge.sv
// tb_stream_to_sdram_bridge
// Directed and randomized checks of stream_to_sdram_bridge. A queue holds the
// words the stream side has had acknowledged; an SDRAM slave model answers
// each SDRAM write from a response plan (or randomly) and compares the word
// against the queue head.
module tb_stream_to_sdram_bridge;

  localparam int          DEPTH    = 16;
  localparam logic [31:0] BASE_ADR = 32'h100;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_ms;
  logic [3:0]  s_sel;
  logic        s_ack, s_err, s_rty;
  logic [31:0] s_dat_sm;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat_ms;
  logic [3:0]  m_sel;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic        m_ack, m_err, m_rty;
  logic [31:0] m_dat_sm;
  logic [15:0] drop_cnt;

  always #5 sys_clk = ~sys_clk;

  stream_to_sdram_bridge #(
    .FIFO_DEPTH (DEPTH),
    .BASE_ADR   (BASE_ADR)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_adr     (s_adr),
    .s_dat_ms  (s_dat_ms),
    .s_sel     (s_sel),
    .s_ack     (s_ack),
    .s_err     (s_err),
    .s_rty     (s_rty),
    .s_dat_sm  (s_dat_sm),
    .m_cyc     (m_cyc),
    .m_stb     (m_stb),
    .m_we      (m_we),
    .m_adr     (m_adr),
    .m_dat_ms  (m_dat_ms),
    .m_sel     (m_sel),
    .m_cti     (m_cti),
    .m_bte     (m_bte),
    .m_ack     (m_ack),
    .m_err     (m_err),
    .m_rty     (m_rty),
    .m_dat_sm  (m_dat_sm),
    .drop_cnt  (drop_cnt)
  );

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];     // accepted words not yet retired on SDRAM
  int   plan[$];      // 0 ack, 1 err, 2 rty, 3 ack+err+rty, 4 err+rty
  int   exp_drop  = 0;
  int   n_cmp     = 0;
  int   n_err     = 0;
  int   n_issue   = 0; // SDRAM cycles answered
  int   n_rty     = 0;
  int   n_deliv   = 0;
  bit   resp_hold = 1'b0;
  bit   rand_mode = 1'b0;
  int   wait_cnt  = 0;
  int   resp_code = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts (or continues) a stream write; leaves the strobe up if not acked.
  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int budget, output bit acked);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1;
    s_adr = adr; s_dat_ms = dat; s_sel = sel;
    acked = 1'b0;
    for (int i = 0; i < budget && !acked; i++) begin
      @(negedge sys_clk);
      if (s_ack) begin
        acked = 1'b1;
        exp_q.push_back('{adr: adr + BASE_ADR, sel: sel, dat: dat});
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (3) @(negedge sys_clk);
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle"}, 64'(m_cyc), 64'd0);
  endtask

  // SDRAM slave model: one response per cycle, optional wait states.
  initial begin
    m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0; m_dat_sm = 32'h0;
    forever begin
      @(negedge sys_clk);
      if (s_ack || s_err) check("ack_err_excl", 64'(s_ack & s_err), 64'd0);
      if (!sys_rst_n) begin
        m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0; wait_cnt = 0;
      end else if (m_ack || m_err || m_rty) begin
        m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0;
      end else if (m_cyc && m_stb && !resp_hold) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          if (plan.size() != 0) resp_code = plan.pop_front();
          else if (rand_mode) begin
            resp_code = $urandom_range(0, 9);
            resp_code = (resp_code <= 5) ? 0 : (resp_code <= 7) ? 2 : (resp_code == 8) ? 1 : 3;
          end else resp_code = 0;
          if (exp_q.size() == 0) begin
            check("sdram_unexpected_cycle", 64'd1, 64'd0);
            m_ack = 1'b1;
          end else begin
            check("sdram_adr", 64'(m_adr), 64'(exp_q[0].adr));
            check("sdram_dat", 64'(m_dat_ms), 64'(exp_q[0].dat));
            check("sdram_sel", 64'(m_sel), 64'(exp_q[0].sel));
            check("sdram_we_cti_bte", 64'({m_we, m_cti, m_bte}), 64'({1'b1, 3'b000, 2'b00}));
            n_issue++;
            m_ack = (resp_code == 0) || (resp_code == 3);
            m_err = (resp_code == 1) || (resp_code >= 3);
            m_rty = (resp_code >= 2);
            // Outcome by priority ack > err > rty
            if (resp_code == 0 || resp_code == 3) begin
              void'(exp_q.pop_front());
              n_deliv++;
            end else if (resp_code == 1 || resp_code == 4) begin
              void'(exp_q.pop_front());
              exp_drop++;
            end else begin
              n_rty++;
            end
          end
          wait_cnt = rand_mode ? $urandom_range(0, 2) : 0;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] wa, wd;
    bit          ok;
    bit          blocked;
    int          accepted;
    int          snap_issue, snap_rty, snap_deliv, n;

    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    s_adr = 32'h0; s_dat_ms = 32'h0; s_sel = 4'h0;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Reset state
    check("rst_s_resp", 64'({s_ack, s_err, s_rty, s_dat_sm}), 64'd0);
    check("rst_m_ctl", 64'({m_cyc, m_stb, m_we, m_cti, m_bte}), 64'd0);
    check("rst_m_adr_dat_sel", {m_adr, m_dat_ms} ^ 64'(m_sel), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Single write, latency t+2, BASE_ADR offset
    resp_hold = 1'b1;
    do_write(32'h10, 32'hCAFEBABE, 4'hF, 8, ok);
    check("t2_acked", 64'(ok), 64'd1);
    @(negedge sys_clk);
    check("t2_single_ack", 64'(s_ack), 64'd0);
    check("t2_m_stb", 64'({m_cyc, m_stb}), 64'h3);
    check("t2_m_adr", 64'(m_adr), 64'h110);
    check("t2_m_dat", 64'(m_dat_ms), 64'hCAFEBABE);
    check("t2_m_sel", 64'(m_sel), 64'hF);
    resp_hold = 1'b0;
    wait_drain("t2");

    // Read attempt: one error pulse, no ack, no SDRAM cycle
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 32'h40;
    @(negedge sys_clk);
    check("t4_err_pulse", 64'({s_err, s_ack}), 64'h2);
    s_cyc = 1'b0; s_stb = 1'b0;
    @(negedge sys_clk);
    check("t4_err_one_cycle", 64'({s_err, s_ack}), 64'h0);
    n = 0;
    repeat (4) begin
      @(negedge sys_clk);
      if (m_cyc) n++;
    end
    check("t4_no_sdram", 64'(n), 64'd0);

    // Back-pressure: SDRAM stalled, 20 writes. One word sits in the master
    // registers, so DEPTH+1 writes are accepted before the stall.
    resp_hold = 1'b1;
    blocked = 1'b0;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      wa = 32'h1000 + 32'(i * 4);
      wd = $urandom;
      if (!blocked) begin
        do_write(wa, wd, 4'hF, 8, ok);
        if (ok) accepted++;
        else begin
          blocked = 1'b1;
          check("t3_accepted_before_full", 64'(accepted), 64'(DEPTH + 1));
          check("t3_no_ack_when_full", 64'(s_ack), 64'd0);
          resp_hold = 1'b0;
          do_write(wa, wd, 4'hF, 200, ok);
          check("t3_resume_ack", 64'(ok), 64'd1);
        end
      end else begin
        do_write(wa, wd, 4'hF, 60, ok);
        check("t3_late_ack", 64'(ok), 64'd1);
      end
    end
    check("t3_did_block", 64'(blocked), 64'd1);
    resp_hold = 1'b0;
    wait_drain("t3");

    // Retry then ack: same word issued twice, nothing dropped
    snap_issue = n_issue; snap_rty = n_rty;
    plan.push_back(2);
    do_write(32'h2000, 32'h1234_5678, 4'h3, 8, ok);
    wait_drain("t5");
    check("t5_issue_count", 64'(n_issue - snap_issue), 64'd2);
    check("t5_rty_count", 64'(n_rty - snap_rty), 64'd1);
    check("t5_drop_cnt", 64'(drop_cnt), 64'd0);

    // Three errors, then words still delivered
    snap_deliv = n_deliv;
    plan.push_back(1); plan.push_back(1); plan.push_back(1);
    for (int i = 0; i < 5; i++) begin
      do_write(32'h3000 + 32'(i * 4), $urandom, 4'hF, 8, ok);
    end
    wait_drain("t6");
    check("t6_drop_cnt", 64'(drop_cnt), 64'd3);
    check("t6_delivered", 64'(n_deliv - snap_deliv), 64'd2);

    // Simultaneous responses: ack wins over err/rty, err wins over rty
    plan.push_back(3); plan.push_back(4);
    do_write(32'h4000, 32'hA5A5_0001, 4'h1, 8, ok);
    do_write(32'h4004, 32'hA5A5_0002, 4'h8, 8, ok);
    wait_drain("prio");
    check("prio_drop_cnt", 64'(drop_cnt), 64'd4);

    // Random traffic with random responses and wait states
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_write($urandom, $urandom, 4'($urandom_range(0, 15)), 40, ok);
      check("rand_acked", 64'(ok), 64'd1);
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
    end
    wait_drain("rand");
    check("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    rand_mode = 1'b0;

    // Reset mid-WRITE with words still buffered
    resp_hold = 1'b1;
    for (int i = 0; i < 3; i++) do_write(32'h5000 + 32'(i * 4), $urandom, 4'hF, 8, ok);
    check("t1_mcyc_before_reset", 64'(m_cyc), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    check("t1_async_clear", 64'({m_cyc, m_stb, m_we}), 64'd0);
    check("t1_drop_cnt_cleared", 64'(drop_cnt), 64'd0);
    exp_q.delete();
    plan.delete();
    exp_drop = 0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    resp_hold = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (m_cyc) n++;
    end
    check("t1_fifo_empty_after_reset", 64'(n), 64'd0);
    check("t1_drop_cnt_after", 64'(drop_cnt), 64'd0);

    // Buffer works normally after reset
    do_write(32'h6000, 32'hDEAD_BEEF, 4'hC, 8, ok);
    check("post_reset_ack", 64'(ok), 64'd1);
    wait_drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
